// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared sizes and writeback request type for the regfile writer
package regfile_wb_ctrl_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int AW         = 5;
  localparam int STARVE_MAX = 4;
  localparam int SW         = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - issue, result, write-port and operand-read signals of the regfile writer
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ready;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            w_en;
  logic [AW-1:0]   write_addr;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_rf;
  logic [XLEN-1:0] rs2_rf;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic            wb_err;

  modport master (
    output alloc_valid, alloc_addr, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
    input  alloc_ready, alu_ready, lsu_ready, w_en, write_addr, write_data,
           rs1_val, rs2_val, stall, wb_err
  );

  modport slave (
    input  alloc_valid, alloc_addr, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
    output alloc_ready, alu_ready, lsu_ready, w_en, write_addr, write_data,
           rs1_val, rs2_val, stall, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bits for registers with outstanding results
module regfile_scoreboard
  import regfile_wb_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            w_en,
  input  logic [AW-1:0]   write_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            alloc_ready,
  output logic            stall,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            rs1_stall;
  logic            rs2_stall;

  // A register being written back this cycle may be re-claimed immediately.
  assign alloc_ready = (alloc_addr == '0) || !busy[alloc_addr] ||
                       (w_en && write_addr == alloc_addr);

  assign rs1_stall = (rs1_addr != '0) && busy[rs1_addr] && !(w_en && write_addr == rs1_addr);
  assign rs2_stall = (rs2_addr != '0) && busy[rs2_addr] && !(w_en && write_addr == rs2_addr);
  assign stall     = rs1_stall || rs2_stall;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (alloc_valid && alloc_ready && alloc_addr != '0)
      set_vec[alloc_addr] = 1'b1;
    if (w_en)
      clr_vec[write_addr] = 1'b1;
  end

  // Set is ORed after the clear so a same-edge re-claim keeps the bit.
  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= (busy & ~clr_vec) | set_vec;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - ALU/LSU writeback arbiter, regfile write port and operand forwarding
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  regfile_wb_ctrl_if.slave bus
);
  logic [SW-1:0]   starve_cnt;
  logic [NREG-1:0] busy;
  logic            force_alu;
  logic            alu_hs;
  logic            lsu_hs;
  logic            any_hs;
  wb_req_t         win;

  // LSU has priority unless the ALU has lost STARVE_MAX times in a row.
  assign force_alu     = (starve_cnt == SW'(STARVE_MAX)) && bus.alu_valid;
  assign bus.alu_ready = force_alu || !bus.lsu_valid;
  assign bus.lsu_ready = !force_alu;

  assign alu_hs = bus.alu_valid && bus.alu_ready;
  assign lsu_hs = bus.lsu_valid && bus.lsu_ready;
  assign any_hs = alu_hs || lsu_hs;
  assign win    = lsu_hs ? '{rd: bus.lsu_rd, data: bus.lsu_data}
                         : '{rd: bus.alu_rd, data: bus.alu_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.w_en       <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
      bus.wb_err     <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      bus.w_en <= any_hs && (win.rd != '0);
      if (any_hs) begin
        bus.write_addr <= win.rd;
        bus.write_data <= win.data;
      end
      if (any_hs && win.rd != '0 && !busy[win.rd])
        bus.wb_err <= 1'b1;
      if (!bus.alu_valid || alu_hs)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.rs1_val = (bus.rs1_addr == '0) ? '0 :
                       (bus.w_en && bus.write_addr == bus.rs1_addr) ? bus.write_data : bus.rs1_rf;
  assign bus.rs2_val = (bus.rs2_addr == '0) ? '0 :
                       (bus.w_en && bus.write_addr == bus.rs2_addr) ? bus.write_data : bus.rs2_rf;

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (bus.alloc_valid),
    .alloc_addr  (bus.alloc_addr),
    .w_en        (bus.w_en),
    .write_addr  (bus.write_addr),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .alloc_ready (bus.alloc_ready),
    .stall       (bus.stall),
    .busy        (busy)
  );
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit ck_en    = 1'b0;

  bit              busy_m [NREG];
  int              starve_m;
  bit              wen_m;
  logic [AW-1:0]   waddr_m;
  logic [XLEN-1:0] wdata_m;
  bit              err_m;

  bit              m_force, m_lsu_win, m_alu_win, m_hs, m_ok;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_stall1(input logic [AW-1:0] a);
    return (a != 0) && busy_m[a] && !(wen_m && waddr_m == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_val(input logic [AW-1:0] a, input logic [XLEN-1:0] rf);
    if (a == 0) return '0;
    if (wen_m && waddr_m == a) return wdata_m;
    return rf;
  endfunction

  // Reference model: advance on each rising edge using the inputs present in that cycle.
  always @(posedge clk) begin
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      starve_m = 0;
      wen_m    = 1'b0;
      waddr_m  = '0;
      wdata_m  = '0;
      err_m    = 1'b0;
    end else begin
      m_force   = (starve_m == STARVE_MAX) && bus.alu_valid;
      m_lsu_win = bus.lsu_valid && !m_force;
      m_alu_win = bus.alu_valid && (m_force || !bus.lsu_valid);
      m_hs      = m_lsu_win || m_alu_win;
      m_rd      = m_lsu_win ? bus.lsu_rd : bus.alu_rd;
      m_data    = m_lsu_win ? bus.lsu_data : bus.alu_data;
      m_ok      = (bus.alloc_addr == 0) || !busy_m[bus.alloc_addr] ||
                  (wen_m && waddr_m == bus.alloc_addr);
      if (m_hs && m_rd != 0 && !busy_m[m_rd]) err_m = 1'b1;
      if (wen_m) busy_m[waddr_m] = 1'b0;
      if (bus.alloc_valid && m_ok && bus.alloc_addr != 0) busy_m[bus.alloc_addr] = 1'b1;
      if (bus.alu_valid && !m_alu_win)
        starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
      else
        starve_m = 0;
      wen_m = m_hs && (m_rd != 0);
      if (m_hs) begin
        waddr_m = m_rd;
        wdata_m = m_data;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (ck_en) begin
      chk("alloc_ready", {31'b0, bus.alloc_ready},
          {31'b0, (bus.alloc_addr == 0) || !busy_m[bus.alloc_addr] || (wen_m && waddr_m == bus.alloc_addr)});
      chk("alu_ready", {31'b0, bus.alu_ready},
          {31'b0, ((starve_m == STARVE_MAX) && bus.alu_valid) || !bus.lsu_valid});
      chk("lsu_ready", {31'b0, bus.lsu_ready},
          {31'b0, !((starve_m == STARVE_MAX) && bus.alu_valid)});
      chk("w_en", {31'b0, bus.w_en}, {31'b0, wen_m});
      chk("wb_err", {31'b0, bus.wb_err}, {31'b0, err_m});
      if (wen_m) begin
        chk("write_addr", {27'b0, bus.write_addr}, {27'b0, waddr_m});
        chk("write_data", bus.write_data, wdata_m);
      end
      chk("rs1_val", bus.rs1_val, exp_val(bus.rs1_addr, bus.rs1_rf));
      chk("rs2_val", bus.rs2_val, exp_val(bus.rs2_addr, bus.rs2_rf));
      chk("stall", {31'b0, bus.stall},
          {31'b0, exp_stall1(bus.rs1_addr) || exp_stall1(bus.rs2_addr)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = a;
    cyc();
    bus.alloc_valid = 1'b0;
  endtask

  initial begin
    bus.alloc_valid = 0; bus.alloc_addr = '0;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.rs1_rf = 32'h0000_0999; bus.rs2_rf = 32'h0000_DEAD;
    rst = 1'b1;
    repeat (2) cyc();
    ck_en = 1'b1;
    chk("rst_w_en", {31'b0, bus.w_en}, 32'd0);
    chk("rst_write_addr", {27'b0, bus.write_addr}, 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_wb_err", {31'b0, bus.wb_err}, 32'd0);
    rst = 1'b0;
    cyc();

    // 1: lone ALU result
    alloc(5'd5);
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    #1 chk("t1_alu_ready", {31'b0, bus.alu_ready}, 32'd1);
    cyc();
    bus.alu_valid = 0;
    chk("t1_w_en", {31'b0, bus.w_en}, 32'd1);
    chk("t1_addr", {27'b0, bus.write_addr}, 32'd5);
    chk("t1_data", bus.write_data, 32'h1234);
    cyc();
    bus.rs1_addr = 5'd5;
    #1 chk("t1_busy_cleared", {31'b0, bus.stall}, 32'd0);
    bus.rs1_addr = '0;

    // 2: simultaneous LSU and ALU
    alloc(5'd3);
    alloc(5'd4);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'hAA;
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'hBB;
    #1 chk("t2_alu_ready_lost", {31'b0, bus.alu_ready}, 32'd0);
    cyc();
    bus.lsu_valid = 0;
    chk("t2_first_addr", {27'b0, bus.write_addr}, 32'd3);
    chk("t2_first_data", bus.write_data, 32'hAA);
    cyc();
    bus.alu_valid = 0;
    chk("t2_second_addr", {27'b0, bus.write_addr}, 32'd4);
    chk("t2_second_data", bus.write_data, 32'hBB);
    cyc();

    // 3: ALU starvation
    alloc(5'd6);
    bus.alu_valid = 1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h77;
    for (int i = 1; i <= STARVE_MAX + 1; i++) begin
      #1;
      chk("t3_alu_ready", {31'b0, bus.alu_ready}, (i == STARVE_MAX + 1) ? 32'd1 : 32'd0);
      chk("t3_lsu_ready", {31'b0, bus.lsu_ready}, (i == STARVE_MAX + 1) ? 32'd0 : 32'd1);
      cyc();
    end
    bus.alu_valid = 0; bus.lsu_valid = 0;
    chk("t3_w_en", {31'b0, bus.w_en}, 32'd1);
    chk("t3_data", bus.write_data, 32'h66);
    cyc();

    // 4: stall and forwarding
    alloc(5'd7);
    bus.rs1_addr = 5'd7;
    #1 chk("t4_stall_busy", {31'b0, bus.stall}, 32'd1);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h55;
    cyc();
    bus.alu_valid = 0;
    #1;
    chk("t4_stall_wb", {31'b0, bus.stall}, 32'd0);
    chk("t4_rs1_fwd", bus.rs1_val, 32'h55);
    chk("t4_rs2_x0", bus.rs2_val, 32'h0);
    cyc();
    chk("t4_rs1_rf", bus.rs1_val, 32'h999);
    bus.rs1_addr = '0;

    // 5: allocation rules
    alloc(5'd9);
    bus.alloc_valid = 1; bus.alloc_addr = 5'd9;
    #1 chk("t5_alloc_busy", {31'b0, bus.alloc_ready}, 32'd0);
    bus.alloc_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    cyc();
    bus.alu_valid = 0;
    bus.alloc_valid = 1; bus.alloc_addr = 5'd9;
    #1 chk("t5_alloc_wb_cycle", {31'b0, bus.alloc_ready}, 32'd1);
    cyc();
    bus.alloc_valid = 0;
    bus.rs1_addr = 5'd9;
    #1 chk("t5_busy_kept", {31'b0, bus.stall}, 32'd1);
    bus.rs1_addr = '0;
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9A;
    cyc();
    bus.alu_valid = 0;
    cyc();
    bus.alloc_valid = 1; bus.alloc_addr = 5'd0;
    #1 chk("t5_alloc_x0", {31'b0, bus.alloc_ready}, 32'd1);
    cyc();
    bus.alloc_valid = 0;
    chk("t5_no_err", {31'b0, bus.wb_err}, 32'd0);

    // 6: error on non-busy target, then reset with a result in flight
    bus.alu_valid = 1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC0;
    cyc();
    bus.alu_valid = 0;
    chk("t6_w_en", {31'b0, bus.w_en}, 32'd1);
    chk("t6_addr", {27'b0, bus.write_addr}, 32'd12);
    chk("t6_err", {31'b0, bus.wb_err}, 32'd1);
    repeat (3) cyc();
    chk("t6_err_sticky", {31'b0, bus.wb_err}, 32'd1);
    alloc(5'd14);
    rst = 1'b1;
    bus.alu_valid = 1; bus.alu_rd = 5'd14; bus.alu_data = 32'hEE;
    cyc();
    rst = 1'b0;
    bus.alu_valid = 0;
    bus.rs2_addr = 5'd14;
    #1;
    chk("t6_rst_w_en", {31'b0, bus.w_en}, 32'd0);
    chk("t6_rst_err", {31'b0, bus.wb_err}, 32'd0);
    chk("t6_rst_busy", {31'b0, bus.stall}, 32'd0);
    cyc();
    chk("t6_no_late_write", {31'b0, bus.w_en}, 32'd0);
    bus.rs2_addr = '0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
